// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed BCD display scanner with a double-buffered load port.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
// state    | meaning
// ST_IDLE  | nothing loaded yet, outputs off
// ST_DWELL | digit r_dig driven for PRESCALE cycles
// ST_BLANK | all-off gap after digit r_dig for BLANK_CYCLES cycles
module bcd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load_valid,
  output logic                    o_load_ready,
  input  logic [4*NUM_DIGITS-1:0] i_load_bcd,
  output logic [NUM_DIGITS-1:0]   o_dig_sel,
  output logic [9:0]              o_dec_out,
  output logic                    o_frame_done,
  output logic                    o_bad_code
);

  localparam int CNT_MAX    = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW         = $clog2(CNT_MAX + 1);
  localparam int DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLANK_LOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DWELL = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;
  // frame_done marks the final cycle of whichever state closes the last slot
  localparam logic [1:0] ST_LAST  = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DWELL;

  localparam logic [CW-1:0] DWELL_TC = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_TC = CW'(BLANK_LOAD);
  localparam logic [DW-1:0] LAST_DIG = DW'(NUM_DIGITS - 1);

  logic [1:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic [DW-1:0]           r_dig;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_pending;
  logic                    r_pend_full;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic                    r_bad;
  logic [NUM_DIGITS-1:0]   r_dig_sel;
  logic [9:0]              r_dec_out;
  logic                    r_frame_done;

  logic [1:0]              w_state_nxt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [DW-1:0]           w_dig_nxt;
  logic                    w_swap;
  logic                    w_accept;
  logic [4*NUM_DIGITS-1:0] w_active_nxt;
  logic [NUM_DIGITS-1:0]   w_mask_nxt;
  logic [NUM_DIGITS-1:0]   w_pend_mask;
  logic                    w_pend_bad;
  logic [3:0]              w_code;
  logic                    w_show;
  logic [NUM_DIGITS-1:0]   w_dig_sel_nxt;
  logic [9:0]              w_dec_nxt;
  logic                    w_frame_done_nxt;

  assign o_load_ready = ~r_pend_full;
  assign w_accept     = i_load_valid & ~r_pend_full;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dig_nxt   = r_dig;
    w_swap      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_full) begin
          w_swap      = 1'b1;
          w_state_nxt = ST_DWELL;
          w_dig_nxt   = '0;
          w_cnt_nxt   = DWELL_TC;
        end
      end
      ST_DWELL, ST_BLANK: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if ((r_state == ST_DWELL) && (BLANK_CYCLES > 0)) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = BLANK_TC;
        end else begin
          w_state_nxt = ST_DWELL;
          w_cnt_nxt   = DWELL_TC;
          if (r_dig == LAST_DIG) begin
            w_dig_nxt = '0;
            w_swap    = r_pend_full;
          end else begin
            w_dig_nxt = r_dig + DW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_dig_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_pend_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_pending[4*i +: 4] > 4'd9) w_pend_bad = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_zero_run;

  // a digit is suppressed while it and everything above it are zero
  always_comb begin
    w_zero_run  = 1'b1;
    w_pend_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run     = w_zero_run & (r_pending[4*i +: 4] == 4'd0);
      w_pend_mask[i] = w_zero_run;
    end
  end
`else
  assign w_pend_mask = '0;
`endif

  assign w_active_nxt = w_swap ? r_pending : r_active;
  assign w_mask_nxt   = w_swap ? w_pend_mask : r_mask;
  assign w_code       = w_active_nxt[4*w_dig_nxt +: 4];
  assign w_show       = (w_state_nxt == ST_DWELL) && !w_mask_nxt[w_dig_nxt];

  always_comb begin
    w_dig_sel_nxt = '0;
    w_dec_nxt     = '0;
    if (w_show) begin
      w_dig_sel_nxt = NUM_DIGITS'(1) << w_dig_nxt;
      if (w_code <= 4'd9) w_dec_nxt = 10'd1 << w_code;
    end
  end

  assign w_frame_done_nxt = (w_state_nxt == ST_LAST) && (w_dig_nxt == LAST_DIG) &&
                            (w_cnt_nxt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_dig        <= '0;
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_full  <= 1'b0;
      r_mask       <= '0;
      r_bad        <= 1'b0;
      r_dig_sel    <= '0;
      r_dec_out    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dig        <= w_dig_nxt;
      r_active     <= w_active_nxt;
      r_mask       <= w_mask_nxt;
      r_dig_sel    <= w_dig_sel_nxt;
      r_dec_out    <= w_dec_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (w_swap) r_bad <= w_pend_bad;
      if (w_accept) r_pending <= i_load_bcd;
      if (w_swap) begin
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_pend_full <= 1'b1;
      end
    end
  end

  assign o_dig_sel    = r_dig_sel;
  assign o_dec_out    = r_dec_out;
  assign o_frame_done = r_frame_done;
  assign o_bad_code   = r_bad;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl with NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1.
// Expectations follow LEADING_ZERO_BLANK_EN the same way the design build does.
module tb_bcd_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_bcd;
  logic [3:0]  dig_sel;
  logic [9:0]  dec_out;
  logic        frame_done;
  logic        bad_code;

  int total = 0;
  int bad   = 0;

  bcd_scan_ctrl #(
    .NUM_DIGITS  (4),
    .PRESCALE    (4),
    .BLANK_CYCLES(1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_load_valid(load_valid),
    .o_load_ready(load_ready),
    .i_load_bcd  (load_bcd),
    .o_dig_sel   (dig_sel),
    .o_dec_out   (dec_out),
    .o_frame_done(frame_done),
    .o_bad_code  (bad_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic suppressed(input logic [15:0] w, input int s);
    logic z;
    z = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (s > 0) begin
      z = 1'b1;
      for (int j = s; j < 4; j++) if (w[4*j +: 4] != 4'd0) z = 1'b0;
    end
`endif
    return z;
  endfunction

  // frame position p: slot = p/5, dwell when p%5 < 4, last blank of slot 3 at p=19
  task automatic run_cycles(input logic [15:0] w, input int start, input int n);
    int         p;
    int         s;
    logic [3:0] code;
    logic [3:0] es;
    logic [9:0] ed;
    for (int k = 0; k < n; k++) begin
      p    = (start + k) % 20;
      s    = p / 5;
      code = w[4*s +: 4];
      es   = '0;
      ed   = '0;
      if ((p % 5 < 4) && !suppressed(w, s)) begin
        es = 4'b0001 << s;
        if (code <= 4'd9) ed = 10'd1 << code;
      end
      chk($sformatf("dig_sel p%0d", p), 32'(dig_sel), 32'(es));
      chk($sformatf("dec_out p%0d", p), 32'(dec_out), 32'(ed));
      chk($sformatf("frame_done p%0d", p), 32'(frame_done), 32'(p == 19));
      tick();
    end
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_bcd   = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst dig_sel", 32'(dig_sel), 32'd0);
    chk("rst dec_out", 32'(dec_out), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst bad_code", 32'(bad_code), 32'd0);
    chk("rst load_ready", 32'(load_ready), 32'd1);

    // load from idle: accepted at T, first digit visible after T+1
    load_valid = 1'b1;
    load_bcd   = 16'h1234;
    tick();
    load_valid = 1'b0;
    chk("idle ready low", 32'(load_ready), 32'd0);
    chk("idle dig_sel", 32'(dig_sel), 32'd0);
    tick();
    chk("startup ready", 32'(load_ready), 32'd1);
    run_cycles(16'h1234, 0, 20);

    // mid-frame load waits for the frame boundary; a held third load follows a cycle later
    load_valid = 1'b1;
    load_bcd   = 16'h5678;
    run_cycles(16'h1234, 0, 1);
    load_bcd = 16'h0987;
    chk("pending ready", 32'(load_ready), 32'd0);
    run_cycles(16'h1234, 1, 18);
    chk("pending ready end", 32'(load_ready), 32'd0);
    run_cycles(16'h1234, 19, 1);
    chk("swap ready", 32'(load_ready), 32'd1);
    run_cycles(16'h5678, 0, 1);
    load_valid = 1'b0;
    chk("third load accepted", 32'(load_ready), 32'd0);
    run_cycles(16'h5678, 1, 19);
    chk("third swap ready", 32'(load_ready), 32'd1);

    // invalid code: slot asserted with no decode, bad_code tracks active word
    load_valid = 1'b1;
    load_bcd   = 16'h12F4;
    run_cycles(16'h0987, 0, 1);
    load_valid = 1'b0;
    chk("bad_code clean", 32'(bad_code), 32'd0);
    run_cycles(16'h0987, 1, 19);
    chk("bad_code set", 32'(bad_code), 32'd1);
    load_valid = 1'b1;
    load_bcd   = 16'h0009;
    run_cycles(16'h12F4, 0, 1);
    load_valid = 1'b0;
    run_cycles(16'h12F4, 1, 19);
    chk("bad_code cleared", 32'(bad_code), 32'd0);

    // reset during DWELL(2) with a pending word that must be discarded
    run_cycles(16'h0009, 0, 8);
    load_valid = 1'b1;
    load_bcd   = 16'h4321;
    run_cycles(16'h0009, 8, 1);
    load_valid = 1'b0;
    chk("pre-rst pending", 32'(load_ready), 32'd0);
    run_cycles(16'h0009, 9, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst dig_sel", 32'(dig_sel), 32'd0);
    chk("midrst dec_out", 32'(dec_out), 32'd0);
    chk("midrst load_ready", 32'(load_ready), 32'd1);
    chk("midrst frame_done", 32'(frame_done), 32'd0);
    chk("midrst bad_code", 32'(bad_code), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("idle stays off dig_sel", 32'(dig_sel), 32'd0);
      chk("idle stays off dec_out", 32'(dec_out), 32'd0);
      chk("idle stays ready", 32'(load_ready), 32'd1);
    end

    // leading zeros: all slots shown unless the suppression build is selected
    load_valid = 1'b1;
    load_bcd   = 16'h0050;
    tick();
    load_valid = 1'b0;
    chk("lz idle dig_sel", 32'(dig_sel), 32'd0);
    tick();
    run_cycles(16'h0050, 0, 20);
    run_cycles(16'h0050, 0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit BCD display, with a double-buffered load interface. It accepts a packed BCD word through a valid/ready handshake and cycles through the digits one at a time. For each digit it drives a one-hot digit select and the 4-to-10 one-hot decimal decode of that digit, with dwell and blanking timing. It sits between the value producer (counter, ALU result) and the digit drivers / one-of-ten indicator lamps.

Parameters:
NUM_DIGITS, 4, number of BCD digits scanned; legal range 1..8
PRESCALE, 1000, clock cycles each digit is driven (dwell); must be >= 1
BLANK_CYCLES, 2, clock cycles of all-off blanking after each dwell; 0 = no blanking

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  synchronous reset, active-high
load_valid  input  1  producer presents a new word on load_bcd
load_ready  output  1  pending buffer empty; a word is accepted on the edge where load_valid && load_ready
load_bcd  input  4*NUM_DIGITS  packed BCD; digit i = bits [4i+3:4i]; digit 0 is least significant
dig_sel  output  NUM_DIGITS  one-hot active-digit enable; all zero when idle or blanking
dec_out  output  10  one-hot decode of the active digit (bit k = value k); all zero when idle, blanking, or invalid code
frame_done  output  1  one-cycle pulse on the last cycle of each frame
bad_code  output  1  high while the active word contains any digit > 9

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All outputs are registered except load_ready = ~pending_full.
- Reset values: dig_sel=0, dec_out=0, frame_done=0, bad_code=0, load_ready=1. The active word and pending buffer are cleared. State is IDLE.
- States:
  - IDLE: outputs off.
  - DWELL(i): dig_sel bit i set; dec_out = decode(digit i).
  - BLANK(i): dig_sel=0, dec_out=0.
- Pending buffer:
  - A handshake at edge T stores load_bcd in pending, setting pending_full. load_ready is low from T until pending is swapped.
  - A swap happens only at a frame boundary, or on the first edge after a load while in IDLE.
  - A swap copies pending to the active word, clears pending_full, and recomputes bad_code from the new active word.
- Start-up latency: a load accepted in IDLE at edge T swaps at edge T+1. DWELL(0) outputs are visible after edge T+1, and load_ready returns high after edge T+1.
- Transitions:
  - DWELL(i) lasts exactly PRESCALE cycles, then goes to BLANK(i).
  - BLANK(i) lasts BLANK_CYCLES cycles, then goes to DWELL(i+1). If BLANK_CYCLES=0, BLANK is skipped.
  - After the last digit, the frame wraps to DWELL(0). If pending_full, the swap happens on that edge; otherwise the active word is repeated.
- Once scanning starts, the block never returns to IDLE except via rst.
- Frame length is NUM_DIGITS*(PRESCALE+BLANK_CYCLES) cycles. frame_done is high during the final cycle of the last digit's slot (last BLANK cycle, or last DWELL cycle when BLANK_CYCLES=0).
- Decode: codes 0..9 give one-hot dec_out. Codes 10..15 give dec_out=0 while dig_sel still asserts normally for that slot.
- Simultaneous swap and load: load_ready is low on the swap edge, so no load is accepted on that edge. A new load can be accepted from the next cycle.
- Reset mid-operation: on the next edge all outputs go to reset values, the pending word is discarded, and state returns to IDLE.
- Counters: the dwell/blank counter is sized ceil(log2(max(PRESCALE,BLANK_CYCLES)+1)) and the digit index is ceil(log2(NUM_DIGITS)). Neither counter passes its terminal count.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: leading-zero digits in the active word are suppressed. A digit is suppressed when it and every more significant digit equal 0. Digit 0 is never suppressed. For a suppressed slot, dig_sel and dec_out stay 0 during DWELL.
- Slot timing, frame length and frame_done are unchanged by the suppression.
- The suppression mask is computed at swap time.
- Undefined: all digits are always shown.

Test Plan:
1. NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1: rst, then load 0x1234 accepted at edge T.
   -> From T+1, dig_sel=0001 and dec_out=0000010000 (d4) for 4 cycles, then 1 blank cycle.
   -> Then dig_sel=0010 with dec_out=0000001000 (d3), followed by d2 and d1 in order.
2. Load 0x1234, then 0x5678 accepted mid-frame.
   -> load_ready stays 0 until the frame boundary; 0x5678 appears in the next frame.
   -> A third load_valid held high is accepted one cycle after that swap.
3. Load 0x12F4.
   -> During slot 1, dig_sel=0010 and dec_out=0; bad_code=1 from the swap.
   -> Then load 0x0009: bad_code=0 after the next frame swap.
4. Assert rst during DWELL(2).
   -> After the next edge, dig_sel=0, dec_out=0, load_ready=1, frame_done=0.
   -> Outputs stay off with no new load.
5. Steady scan with config 1.
   -> frame_done pulses once every 20 cycles, coincident with the last blank cycle of digit 3.
6. Load 0x0050 with LEADING_ZERO_BLANK_EN defined.
   -> Slots 3 and 2 show dig_sel=0; slot 1 shows d5 and slot 0 shows d0.
   -> With the macro undefined, all four slots are asserted.
